patternbuf_db: RTL and testbench

Double-buffered, parametrised pattern buffer for the PAT core.
- Two banks of DEPTH fields × WIDTH bits each. PAT reads and writes the active bank using binary field addresses.
- The serial port loads the other (shadow) bank in the background.
- A handshake swaps the two banks atomically, so serial loading no longer stalls or corrupts a running pattern.
- Sits between the serial configuration interface and the PAT field datapath.

---
 rtl/patternbuf_pkg.sv | 18 +
 rtl/patternbuf_bank.sv | 86 ++++++++
 rtl/patternbuf_db.sv | 165 ++++++++++++++++
 tb/tb_patternbuf_db.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/patternbuf_pkg.sv
// Shared types and helpers for the double-buffered pattern buffer.
// The optional parity feature is enabled with `define PATBUF_PARITY_EN.
package patternbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_LOADED = 2'd2
  } state_e;

  localparam int PAR_MAX_W = 64;

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/patternbuf_bank.sv
// One storage bank: serial shift chain, addressed write, combinational read.
// With PATBUF_PARITY_EN defined each field also keeps an even-parity bit.
module patternbuf_bank
  import patternbuf_pkg::*;
#(
  parameter int  DEPTH = 22,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             shift_in_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             msb_o
`ifdef PATBUF_PARITY_EN
  ,
  input  logic             par_refresh_i,
  output logic             rd_par_o
`endif
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        wr_hit_s;
  logic                        rd_hit_s;

  assign wr_hit_s = (int'(wr_addr_i) < DEPTH);
  assign rd_hit_s = (int'(rd_addr_i) < DEPTH);
  assign msb_o    = mem_q[DEPTH-1][WIDTH-1];

  // Field storage: the top never shifts and writes the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (shift_en_i) begin
      mem_q[0] <= {mem_q[0][WIDTH-2:0], shift_in_i};
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= {mem_q[i][WIDTH-2:0], mem_q[i-1][WIDTH-1]};
      end
    end else if (wr_en_i && wr_hit_s) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Out-of-range addresses read as zero.
  always_comb begin
    rd_data_o = '0;
    if (rd_hit_s) begin
      rd_data_o = mem_q[rd_addr_i];
    end else begin
      rd_data_o = '0;
    end
  end

`ifdef PATBUF_PARITY_EN
  logic [DEPTH-1:0] par_q;

  // Parity follows addressed writes; a refresh re-derives all fields after a serial load.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= '0;
    end else if (par_refresh_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_q[i] <= even_parity(PAR_MAX_W'(mem_q[i]));
      end
    end else if (wr_en_i && wr_hit_s) begin
      par_q[wr_addr_i] <= even_parity(PAR_MAX_W'(wr_data_i));
    end
  end

  // Stored parity bit of the addressed field, zero when out of range.
  always_comb begin
    rd_par_o = 1'b0;
    if (rd_hit_s) begin
      rd_par_o = par_q[rd_addr_i];
    end else begin
      rd_par_o = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/patternbuf_db.sv
// Double-buffered pattern buffer: PAT uses the active bank while the serial port
// fills the shadow bank; a handshake swaps them. Optional parity: PATBUF_PARITY_EN.
module patternbuf_db
  import patternbuf_pkg::*;
#(
  parameter int  DEPTH = 22,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH*WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ssel,
  input  logic             sin,
  output logic             sout,
  output logic             load_done,
  output logic             load_err,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             active_bank,
  input  logic [AW-1:0]    field_addr,
  output logic [WIDTH-1:0] field_byte,
  input  logic             field_write,
  input  logic [AW-1:0]    field_waddr,
  input  logic [WIDTH-1:0] field_in
`ifdef PATBUF_PARITY_EN
  ,
  output logic             field_perr
`endif
);

  localparam int NBITS = DEPTH * WIDTH;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             active_q;
  logic             load_done_q;
  logic             load_err_q;
  logic             swap_ack_q;
  logic [WIDTH-1:0] field_byte_q;

  logic             swap_fire_s;
  logic [1:0]       shift_en_s;
  logic [1:0]       wr_en_s;
  logic [1:0]       msb_s;
  logic [WIDTH-1:0] rd_data_s [2];

  // A swap needs an idle serial port and no write in flight to the active bank.
  assign swap_fire_s = (state_q == ST_LOADED) && !ssel && swap_req && !field_write;
  assign shift_en_s  = ssel ? (active_q ? 2'b01 : 2'b10) : 2'b00;
  assign wr_en_s     = field_write ? (active_q ? 2'b10 : 2'b01) : 2'b00;

`ifdef PATBUF_PARITY_EN
  logic       rd_par_s [2];
  logic       field_perr_q;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    patternbuf_bank #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH)
    ) u_bank (
      .clk          (clk),
      .rst          (rst),
      .shift_en_i   (shift_en_s[b]),
      .shift_in_i   (sin),
      .wr_en_i      (wr_en_s[b]),
      .wr_addr_i    (field_waddr),
      .wr_data_i    (field_in),
      .rd_addr_i    (field_addr),
      .rd_data_o    (rd_data_s[b]),
      .msb_o        (msb_s[b])
`ifdef PATBUF_PARITY_EN
      ,
      .par_refresh_i(swap_fire_s && (1'(b) != active_q)),
      .rd_par_o     (rd_par_s[b])
`endif
    );
  end

  // Load/swap controller with its registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      swap_ack_q  <= 1'b0;
    end else begin
      load_err_q <= 1'b0;
      swap_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ssel) begin
            cnt_q   <= CW'(1);
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ssel) begin
            if (cnt_q == CW'(NBITS-1)) begin
              cnt_q       <= '0;
              load_done_q <= 1'b1;
              state_q     <= ST_LOADED;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            load_err_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
          end
        end
        ST_LOADED: begin
          if (ssel) begin
            load_done_q <= 1'b0;
            cnt_q       <= CW'(1);
            state_q     <= ST_SHIFT;
          end else if (swap_fire_s) begin
            active_q    <= ~active_q;
            swap_ack_q  <= 1'b1;
            load_done_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          load_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Read port register; on a swap cycle active_q still names the pre-swap bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      field_byte_q <= '0;
    end else begin
      field_byte_q <= rd_data_s[active_q];
    end
  end

`ifdef PATBUF_PARITY_EN
  // Parity check registered alongside the read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      field_perr_q <= 1'b0;
    end else begin
      field_perr_q <= rd_par_s[active_q] ^ even_parity(PAR_MAX_W'(rd_data_s[active_q]));
    end
  end

  assign field_perr = field_perr_q;
`endif

  assign sout        = active_q ? msb_s[0] : msb_s[1];
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;
  assign swap_ack    = swap_ack_q;
  assign active_bank = active_q;
  assign field_byte  = field_byte_q;

endmodule

// File: tb/tb_patternbuf_db.sv
// Scoreboard bench for patternbuf_db: stimulus pushes expected outputs from a
// bank-level reference model, a monitor pops and compares after every clock edge.
module tb_patternbuf_db;

  localparam int DEPTH = 22;
  localparam int WIDTH = 8;
  localparam int AW    = 5;
  localparam int N     = DEPTH * WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             ssel = 1'b0;
  logic             sin = 1'b0;
  logic             swap_req = 1'b0;
  logic             field_write = 1'b0;
  logic [AW-1:0]    field_addr = '0;
  logic [AW-1:0]    field_waddr = '0;
  logic [WIDTH-1:0] field_in = '0;
  wire              sout, load_done, load_err, swap_ack, active_bank;
  wire [WIDTH-1:0]  field_byte;
`ifdef PATBUF_PARITY_EN
  wire              field_perr;
`endif

  patternbuf_db dut (
    .clk        (clk),
    .rst        (rst),
    .ssel       (ssel),
    .sin        (sin),
    .sout       (sout),
    .load_done  (load_done),
    .load_err   (load_err),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .active_bank(active_bank),
    .field_addr (field_addr),
    .field_byte (field_byte),
    .field_write(field_write),
    .field_waddr(field_waddr),
    .field_in   (field_in)
`ifdef PATBUF_PARITY_EN
    ,
    .field_perr (field_perr)
`endif
  );

  typedef struct packed {
    logic [WIDTH-1:0] fb;
    logic             ld;
    logic             le;
    logic             ack;
    logic             ab;
    logic             so;
    logic             pe;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: two arrays of fields, which one is active, bits received in
  // the current frame and whether a complete frame waits in the shadow bank.
  logic [WIDTH-1:0] mb  [2][DEPTH];
  bit               bad [2][DEPTH];
  int               act = 0;
  int               cnt = 0;
  bit               loaded = 1'b0;
  bit               corrupt_pending = 1'b0;

  function automatic obs_t model_step(bit r, bit s, bit si, bit sr, bit fw,
                                      int wa, logic [WIDTH-1:0] wd, int ra);
    obs_t           o;
    logic [N-1:0]   v;
    int             sh;
    int             pre;
    o = '0;
    if (r) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < DEPTH; i++) begin
          mb[b][i]  = '0;
          bad[b][i] = 1'b0;
        end
      act = 0; cnt = 0; loaded = 1'b0;
      return o;
    end
    pre = act;
    sh  = 1 - act;
    if (ra < DEPTH) begin
      o.fb = mb[pre][ra];
      o.pe = bad[pre][ra];
    end
    if (s) begin
      // Shadow bank viewed as one long shift register, field 0 at the bottom.
      for (int i = 0; i < DEPTH; i++) v[i*WIDTH +: WIDTH] = mb[sh][i];
      v = {v[N-2:0], si};
      for (int i = 0; i < DEPTH; i++) mb[sh][i] = v[i*WIDTH +: WIDTH];
      if (loaded) begin
        loaded = 1'b0;
        cnt    = 1;
      end else begin
        cnt = cnt + 1;
      end
      if (cnt == N) begin
        loaded = 1'b1;
        cnt    = 0;
      end
    end else if (cnt > 0) begin
      o.le = 1'b1;
      cnt  = 0;
    end else if (loaded && sr && !fw) begin
      for (int i = 0; i < DEPTH; i++) bad[sh][i] = 1'b0;
      act    = sh;
      o.ack  = 1'b1;
      loaded = 1'b0;
    end
    if (fw && wa < DEPTH) begin
      mb[pre][wa]  = wd;
      bad[pre][wa] = 1'b0;
    end
    o.ld = loaded;
    o.ab = act[0];
    o.so = mb[1-act][DEPTH-1][WIDTH-1];
    return o;
  endfunction

  task automatic cycle(input bit r, input bit s, input bit si, input bit sr, input bit fw,
                       input int wa, input logic [WIDTH-1:0] wd, input int ra);
    @(negedge clk);
    rst         = r;
    ssel        = s;
    sin         = si;
    swap_req    = sr;
    field_write = fw;
    field_waddr = AW'(wa);
    field_in    = wd;
    field_addr  = AW'(ra);
`ifdef PATBUF_PARITY_EN
    if (corrupt_pending) begin
      corrupt_pending = 1'b0;
      if (act == 0)
        dut.g_bank[0].u_bank.mem_q[2][0] = ~dut.g_bank[0].u_bank.mem_q[2][0];
      else
        dut.g_bank[1].u_bank.mem_q[2][0] = ~dut.g_bank[1].u_bank.mem_q[2][0];
      mb[act][2][0] = ~mb[act][2][0];
      bad[act][2]   = 1'b1;
    end
`endif
    exp_q.push_back(model_step(r, s, si, sr, fw, wa, wd, ra));
  endtask

  task automatic idle(input int ra);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, ra);
  endtask

  task automatic send_frame(input logic [N-1:0] v, input int wr_at, input int wr_addr,
                            input logic [WIDTH-1:0] wr_d, input bit rnd);
    bit               fw;
    int               wa;
    logic [WIDTH-1:0] wd;
    for (int i = N - 1; i >= 0; i--) begin
      fw = 1'b0; wa = 0; wd = '0;
      if (N - 1 - i == wr_at) begin
        fw = 1'b1; wa = wr_addr; wd = wr_d;
      end else if (rnd && $urandom_range(0, 3) == 0) begin
        fw = 1'b1; wa = $urandom_range(0, 31); wd = WIDTH'($urandom);
      end
      cycle(1'b0, 1'b1, v[i], 1'($urandom_range(0, 1)), fw, wa, wd, $urandom_range(0, 31));
    end
  endtask

  // Monitor: every clock edge produces one observation to check.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.fb  = field_byte;
        a.ld  = load_done;
        a.le  = load_err;
        a.ack = swap_ack;
        a.ab  = active_bank;
        a.so  = sout;
`ifdef PATBUF_PARITY_EN
        a.pe  = field_perr;
`else
        a.pe  = 1'b0;
`endif
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got fb=%h ld=%b le=%b ack=%b ab=%b so=%b pe=%b want fb=%h ld=%b le=%b ack=%b ab=%b so=%b pe=%b",
                   $time, a.fb, a.ld, a.le, a.ack, a.ab, a.so, a.pe,
                   e.fb, e.ld, e.le, e.ack, e.ab, e.so, e.pe);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] v;

    // Reset, then read every field of the cleared active bank.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 0);
    for (int a = 0; a < DEPTH; a++) idle(a);

    // Full frame of field k = A0+k, swap, then read back.
    for (int k = 0; k < DEPTH; k++) v[k*WIDTH +: WIDTH] = WIDTH'(8'hA0 + k);
    send_frame(v, -1, 0, '0, 1'b0);
    idle(0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 0);
    idle(5);
    for (int a = 0; a < DEPTH; a++) idle(a);

    // Short frame: error pulse, later swap request must be ignored.
    for (int i = 0; i < 100; i++)
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, '0, 5);
    idle(5);
    idle(5);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 7);

    // Write addr 3 while shifting, deferred swap under writes, then drain via sout.
    for (int k = 0; k < N; k++) v[k] = 1'($urandom_range(0, 1));
    send_frame(v, 40, 3, 8'h5C, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7, WIDTH'($urandom), 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, '0, 3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 3);
    for (int i = 0; i < N - 1; i++)
      cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, '0, $urandom_range(0, 31));
    idle(0);

    // Out-of-range write and read.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 25, 8'hFF, 25);
    idle(25);
    for (int a = 0; a < DEPTH; a++) idle(a);

    // Randomized full frames with concurrent traffic, swaps and reads.
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < N; k++) v[k] = 1'($urandom_range(0, 1));
      send_frame(v, -1, 0, '0, 1'b1);
      for (int i = 0; i < 12; i++)
        cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
              $urandom_range(0, 31), WIDTH'($urandom), $urandom_range(0, 31));
    end

    // Fully random inputs including occasional reset.
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
            WIDTH'($urandom), $urandom_range(0, 31));

    // Reset mid-shift.
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 8'h33, 2);
    idle(2);

`ifdef PATBUF_PARITY_EN
    // Corrupt a stored bit at addr 2; a clean write then clears the error.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h96, 2);
    idle(2);
    corrupt_pending = 1'b1;
    idle(2);
    idle(2);
    idle(1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h41, 0);
    idle(2);
`endif

    idle(0);
    idle(0);
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
